// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and M-extension decode constants for the multiply/divide sequencer
package muldiv_pkg;
  localparam logic [6:0] M_OPCODE = 7'b0110011;
  localparam logic [6:0] M_FUNCT7 = 7'b0000001;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } mdop_t;
endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: issue/writeback/stall bundle between the pipeline and the multiply/divide sequencer
interface muldiv_seq_if #(parameter int WIDTH = 32);
  logic             req_valid, req_ready, flush, stall, res_valid;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] op_a, op_b, result;
  logic [4:0]       rd_in, res_rd;
  modport master (output req_valid, funct3, op_a, op_b, rd_in, flush,
                  input  req_ready, stall, res_valid, result, res_rd);
  modport slave  (input  req_valid, funct3, op_a, op_b, rd_in, flush,
                  output req_ready, stall, res_valid, result, res_rd);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one iteration of shift-add multiply or restoring shift-subtract divide on {hi,lo}
module muldiv_step #(parameter int WIDTH = 32) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  logic [WIDTH:0]   w_sum, w_sh;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  // multiply shifts {carry,hi,lo} right; divide shifts {rem,quo} left and trial-subtracts
  always_comb begin
    w_sum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_m} : '0);
    w_sh   = {i_hi, i_lo[WIDTH-1]};
    w_ge   = w_sh >= {1'b0, i_m};
    w_diff = w_sh[WIDTH-1:0] - i_m;
    o_hi   = i_div ? (w_ge ? w_diff : w_sh[WIDTH-1:0]) : w_sum[WIDTH:1];
    o_lo   = i_div ? {i_lo[WIDTH-2:0], w_ge} : {w_sum[0], i_lo[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide unit that stalls the pipeline while it iterates
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic         clk,
  input logic         arst,
  muldiv_seq_if.slave bus
);
  state_t           r_state, w_next;
  mdop_t            r_op, w_op;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_rd, r_res_rd;
  logic             r_neg, w_neg, w_sa, w_sb, w_div, w_dz, w_ovf, w_special, w_accept;
  logic [WIDTH-1:0] r_hi, r_lo, r_m, r_result, w_hi, w_lo, w_ma, w_mb, w_spec_res, w_q, w_r, w_fix;
  logic [2*WIDTH-1:0] w_prod;
  always_comb begin
    w_op       = mdop_t'(bus.funct3);
    w_div      = bus.funct3[2];
    w_sa       = (w_op inside {MULH, MULHSU, DIV, REM}) && bus.op_a[WIDTH-1];
    w_sb       = (w_op inside {MULH, DIV, REM}) && bus.op_b[WIDTH-1];
    w_ma       = w_sa ? -bus.op_a : bus.op_a;
    w_mb       = w_sb ? -bus.op_b : bus.op_b;
    w_neg      = (w_div && bus.funct3[1]) ? w_sa : w_sa ^ w_sb;
    w_dz       = w_div && (bus.op_b == '0);
    w_ovf      = (w_op inside {DIV, REM}) && (bus.op_a == {1'b1, {WIDTH-1{1'b0}}}) && (&bus.op_b);
    w_special  = w_dz || w_ovf;
    w_spec_res = w_dz ? (bus.funct3[1] ? bus.op_a : '1) : (bus.funct3[1] ? '0 : {1'b1, {WIDTH-1{1'b0}}});
    bus.req_ready = (r_state == IDLE) && !bus.flush;
    w_accept      = bus.req_valid && bus.req_ready;
    bus.stall     = (bus.req_valid && r_state == IDLE && !w_special && !bus.flush) || r_state == CALC || r_state == FIX;
    bus.res_valid = (r_state == DONE) && !bus.flush;
    bus.result    = r_result;
    bus.res_rd    = r_res_rd;
    w_prod = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
    w_q    = r_neg ? -r_lo : r_lo;
    w_r    = r_neg ? -r_hi : r_hi;
    w_fix  = (r_op == MUL) ? w_prod[WIDTH-1:0] : !r_op[2] ? w_prod[2*WIDTH-1:WIDTH] : r_op[1] ? w_r : w_q;
  end
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_accept) w_next = w_special ? DONE : CALC;
    if (r_state == CALC && &r_cnt) w_next = FIX;
    if (r_state == FIX) w_next = DONE;
    if (r_state == DONE || bus.flush) w_next = IDLE;
  end
  always_ff @(posedge clk or posedge arst)
    if (arst) r_state <= IDLE;
    else r_state <= w_next;
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div(r_op[2]), .i_hi(r_hi), .i_lo(r_lo), .i_m(r_m), .o_hi(w_hi), .o_lo(w_lo)
  );
  // lo starts as multiplier (multiply) or dividend (divide); m is multiplicand or divisor
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      r_op <= MUL; r_cnt <= '0; r_rd <= '0; r_res_rd <= '0; r_neg <= 1'b0;
      r_hi <= '0; r_lo <= '0; r_m <= '0; r_result <= '0;
    end else if (w_accept) begin
      r_op  <= w_op;
      r_rd  <= bus.rd_in;
      r_neg <= w_neg;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= w_div ? w_ma : w_mb;
      r_m   <= w_div ? w_mb : w_ma;
      if (w_special) begin
        r_result <= w_spec_res;
        r_res_rd <= bus.rd_in;
      end
    end else if (r_state == CALC && !bus.flush) begin
      r_hi  <= w_hi;
      r_lo  <= w_lo;
      r_cnt <= r_cnt + 1'b1;
    end else if (r_state == FIX && !bus.flush) begin
      r_result <= w_fix;
      r_res_rd <= r_rd;
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed-vector bench for the iterative multiply/divide sequencer
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic arst = 1'b1;
  int checks = 0;
  int errors = 0;
  muldiv_seq_if bus ();
  muldiv_seq dut (.clk(clk), .arst(arst), .bus(bus));
  always #5 clk = ~clk;

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        output logic [31:0] res, output logic [4:0] rrd, output int lat, output int stalls);
    res = 'x; rrd = 'x; lat = -1; stalls = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.funct3 = f3; bus.op_a = a; bus.op_b = b; bus.rd_in = rd;
    #1 if (bus.stall) stalls++;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        res = bus.result; rrd = bus.res_rd; lat = i;
        break;
      end
      if (bus.stall) stalls++;
      @(posedge clk);
    end
  endtask

  task automatic test_reset;
    #2;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.req_ready); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", bus.stall); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.res_valid); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL rst_result got %h exp 0", bus.result); end
    checks++; if (bus.res_rd !== 5'd0) begin errors++; $display("FAIL rst_rd got %0d exp 0", bus.res_rd); end
    @(negedge clk);
    arst = 1'b0;
  endtask

  task automatic test_mul;
    logic [31:0] r; logic [4:0] d; int lat, st;
    run_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd9, r, d, lat, st);
    checks++; if (r !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_res got %h exp ffffffeb", r); end
    checks++; if (d !== 5'd9) begin errors++; $display("FAIL mul_rd got %0d exp 9", d); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency got %0d exp 33", lat); end
    checks++; if (st !== 34) begin errors++; $display("FAIL mul_stall_cycles got %0d exp 34", st); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mul_done_stall got %b exp 0", bus.stall); end
    @(negedge clk);
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL mul_valid_pulse got %b exp 0", bus.res_valid); end
  endtask

  task automatic test_mulh;
    logic [31:0] r; logic [4:0] d; int lat, st;
    run_op(3'b001, 32'h80000000, 32'h80000000, 5'd1, r, d, lat, st);
    checks++; if (r !== 32'h40000000) begin errors++; $display("FAIL mulh got %h exp 40000000", r); end
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, r, d, lat, st);
    checks++; if (r !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulhu got %h exp fffffffe", r); end
    checks++; if (d !== 5'd2) begin errors++; $display("FAIL mulhu_rd got %0d exp 2", d); end
    run_op(3'b010, 32'hFFFFFFFF, 32'd2, 5'd3, r, d, lat, st);
    checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulhsu got %h exp ffffffff", r); end
  endtask

  task automatic test_div;
    logic [31:0] r; logic [4:0] d; int lat, st;
    run_op(3'b100, 32'hFFFFFFF9, 32'd2, 5'd4, r, d, lat, st);
    checks++; if (r !== 32'hFFFFFFFD) begin errors++; $display("FAIL div got %h exp fffffffd", r); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency got %0d exp 33", lat); end
    run_op(3'b110, 32'hFFFFFFF9, 32'd2, 5'd5, r, d, lat, st);
    checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem got %h exp ffffffff", r); end
    run_op(3'b101, 32'hFFFFFFFF, 32'd2, 5'd6, r, d, lat, st);
    checks++; if (r !== 32'h7FFFFFFF) begin errors++; $display("FAIL divu got %h exp 7fffffff", r); end
    run_op(3'b111, 32'd100, 32'd7, 5'd7, r, d, lat, st);
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL remu got %h exp 2", r); end
    checks++; if (d !== 5'd7) begin errors++; $display("FAIL remu_rd got %0d exp 7", d); end
  endtask

  task automatic test_special;
    logic [31:0] r; logic [4:0] d; int lat, st;
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd10, r, d, lat, st);
    checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL div_ovf got %h exp 80000000", r); end
    checks++; if (lat !== 0 || st !== 0) begin errors++; $display("FAIL div_ovf_timing got lat %0d stall %0d exp 0 0", lat, st); end
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd11, r, d, lat, st);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL rem_ovf got %h exp 0", r); end
    run_op(3'b100, 32'd5, 32'd0, 5'd12, r, d, lat, st);
    checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_zero got %h exp ffffffff", r); end
    checks++; if (lat !== 0 || st !== 0) begin errors++; $display("FAIL div_zero_timing got lat %0d stall %0d exp 0 0", lat, st); end
    run_op(3'b110, 32'd5, 32'd0, 5'd13, r, d, lat, st);
    checks++; if (r !== 32'd5) begin errors++; $display("FAIL rem_zero got %h exp 5", r); end
    checks++; if (d !== 5'd13) begin errors++; $display("FAIL rem_zero_rd got %0d exp 13", d); end
    checks++; if (lat !== 0 || st !== 0) begin errors++; $display("FAIL rem_zero_timing got lat %0d stall %0d exp 0 0", lat, st); end
  endtask

  task automatic test_flush;
    logic [31:0] r; logic [4:0] d; int lat, st;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.funct3 = 3'b000; bus.op_a = 32'd5; bus.op_b = 32'd6; bus.rd_in = 5'd20;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL flush_pre_stall got %b exp 1", bus.stall); end
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b exp 0", bus.stall); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", bus.res_valid); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", bus.req_ready); end
    checks++; if (bus.result !== 32'd5 || bus.res_rd !== 5'd13) begin errors++; $display("FAIL flush_keep got %h/%0d exp 5/13", bus.result, bus.res_rd); end
    run_op(3'b011, 32'h00010000, 32'h00030000, 5'd21, r, d, lat, st);
    checks++; if (r !== 32'd3) begin errors++; $display("FAIL flush_next_res got %h exp 3", r); end
    checks++; if (lat !== 33 || d !== 5'd21) begin errors++; $display("FAIL flush_next_timing got lat %0d rd %0d exp 33 21", lat, d); end
  endtask

  task automatic test_async_reset;
    logic [31:0] r; logic [4:0] d; int lat, st;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.funct3 = 3'b100; bus.op_a = 32'd1000; bus.op_b = 32'd3; bus.rd_in = 5'd25;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 arst = 1'b1;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL arst_stall got %b exp 0", bus.stall); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", bus.res_valid); end
    checks++; if (bus.result !== 32'h0 || bus.res_rd !== 5'd0) begin errors++; $display("FAIL arst_result got %h/%0d exp 0/0", bus.result, bus.res_rd); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %b exp 1", bus.req_ready); end
    @(negedge clk);
    arst = 1'b0;
    run_op(3'b000, 32'h00012345, 32'h00000010, 5'd26, r, d, lat, st);
    checks++; if (r !== 32'h00123450) begin errors++; $display("FAIL arst_next_res got %h exp 00123450", r); end
    checks++; if (lat !== 33 || d !== 5'd26) begin errors++; $display("FAIL arst_next_timing got lat %0d rd %0d exp 33 26", lat, d); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.flush = 1'b0; bus.funct3 = 3'b000;
    bus.op_a = '0; bus.op_b = '0; bus.rd_in = '0;
    test_reset;
    test_mul;
    test_mulh;
    test_div;
    test_special;
    test_flush;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer that runs beside the single-cycle ALU in the 3-stage pipeline.
- Accepts one M-extension operation from the decode/register stage and stalls the pipeline while it iterates.
- Returns a 32-bit result with its destination register index for writeback.
- One shared shift/add/subtract datapath serves all eight funct3 variants under a small FSM.

Parameters:
- WIDTH, 32, operand/result width; special-case constants are defined for 32.
- CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
- clk  in  1  pipeline clock (PLL 80 MHz domain).
- arst  in  1  asynchronous, active-high reset.
- req_valid  in  1  M-op present in decode stage (opcode 0110011, funct7 0000001).
- req_ready  out  1  unit can accept; = (state==IDLE) && !flush.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  WIDTH  rs1 value (after forwarding mux).
- op_b  in  WIDTH  rs2 value (after forwarding mux).
- rd_in  in  5  destination register index.
- flush  in  1  branch/jump kill; aborts any operation.
- stall  out  1  freeze pc and pipeline registers.
- res_valid  out  1  one-cycle writeback strobe.
- result  out  WIDTH  result, registered.
- res_rd  out  5  destination index paired with result, registered.

Behaviour:
- Reset (arst high, asynchronous): state IDLE, counter 0, result 0, res_rd 0, all internal operand/accumulator registers 0. res_valid=0, stall=0, req_ready=1 (combinational from IDLE).
- Accept: a request is accepted on an edge where req_valid && req_ready. At that edge the unit latches funct3, rd_in, sign flags and operand magnitudes. Signedness per funct3: MULH/DIV/REM treat both operands as signed; MULHSU treats a as signed and b as unsigned; the rest are unsigned.
- Special cases (decided at accept, no iteration). The unit goes IDLE->DONE and res_valid rises 1 edge after accept. stall is never asserted for these.
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a.
  - Signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Normal path: states IDLE -> CALC -> FIX -> DONE -> IDLE.
  - CALC: 32 iterations, one per edge, counter 0..31; leave CALC on the edge where counter==31.
  - Multiply: shift-add on magnitudes into a 64-bit accumulator.
  - Divide: restoring shift-subtract into a 32-bit remainder and quotient.
  - FIX (1 edge): conditional two's-complement negate. Product sign is sa^sb; quotient sign is sa^sb; remainder sign is sa. Then select the low word (MUL), the high word (MULH*), the quotient or the remainder, and register it into result.
  - DONE: res_valid=1 for exactly one cycle, then IDLE unconditionally. There is no backpressure.
  - Latency: res_valid is high in the cycle after the 33rd edge following the accept edge.
- stall = (req_valid && state==IDLE && !special && !flush) || state==CALC || state==FIX. The first term is combinational so the issuing instruction holds in decode on the accept cycle. stall is low in DONE, so the pipeline advances in the same cycle as writeback.
- flush:
  - In any state, the next edge forces IDLE.
  - res_valid = (state==DONE) && !flush.
  - flush together with req_valid in IDLE means no accept.
  - result/res_rd keep their last values.
- Back-to-back: a new request can be accepted in the cycle after DONE (first IDLE cycle).
- Arithmetic: every intermediate is at least WIDTH+1 bits so no carry is lost. Negation of 0x80000000 magnitude stays in unsigned magnitude form internally.

Decomposition:
- muldiv_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, CALC, FIX, DONE};
  - typedef enum logic [2:0] mdop_t with the eight funct3 encodings;
  - constants M_OPCODE=7'b0110011 and M_FUNCT7=7'b0000001, for the hazard and decode logic to reuse.
- One sub-module, muldiv_step: the combinational single-iteration datapath (one add-or-shift for multiply, one trial-subtract for divide).
- FSM, counter and registers stay in muldiv_seq.

Test Plan:
1. MUL op_a=7, op_b=0xFFFFFFFD: stall is high from the accept cycle through FIX (34 cycles total). result=0xFFFFFFEB and res_valid is high for one cycle, 33 edges after accept, with res_rd=rd_in.
2. MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
3. DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM 0xFFFFFFF9/2 -> 0xFFFFFFFF. DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF. REMU 100/7 -> 2.
4. DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with res_valid 1 edge after accept and stall never high. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
5. flush at the 10th CALC cycle: IDLE next edge, no res_valid, stall low. A new MULHU request in the following cycle is accepted and completes normally.
6. arst pulsed mid-CALC (asynchronously, between edges): state IDLE, stall and res_valid drop immediately, result=0. After release, req_ready=1 and a fresh MUL completes correctly.
